led_pattern_gen: RTL
====================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised LED pattern generator; successor to the fixed 16-bit right-shifter.
//  Sits behind the ICAP controller as a reconfigurable-partition payload that drives board LEDs.
//  Uses a single-cycle clock-enable tick from an internal divider; there is no derived clock.
//  Runtime mode: rotate right, rotate left, bounce, hold.
// PARAMETERS
//  LED_W   16          number of LEDs, >=2
//  DIV     10_000_000  sys_clk cycles per pattern step, >=1 (DIV=1: step every enabled cycle)
// PORTS
//  sys_clk    in   1      system clock, all logic rising-edge
//  sys_rst_n  in   1      asynchronous active-low reset
//  enable     in   1      1 = divider counts and pattern steps; 0 = both frozen
//  mode       in   2      00 rot-right, 01 rot-left, 10 bounce, 11 hold
//  led        out  LED_W  LED pattern, registered
//  tick       out  1      one-cycle pulse marking each pattern step
//  load_stb   in   1      (LED_LOAD_EN only) load request
//  load_val   in   LED_W  (LED_LOAD_EN only) pattern to load
// BEHAVIOUR
//  Reset (async assert, sync release): led=1<<(LED_W-1), cnt=0, tick=0, dir=RIGHT.
//  Divider: cnt increments when enable=1. When cnt==DIV-1, cnt wraps to 0 and tick=1 next cycle
//   (tick registered). enable=0: cnt holds, tick=0. First tick follows DIV enabled cycles after reset.
//  Step: led updates in the same cycle tick is high (led registered from the tick-cycle state);
//   latency is DIV enabled cycles from reset to the first change.
//  mode is sampled only on the step cycle; a mid-period change takes effect at the next step.
//  00 rot-right: led <= {led[0], led[LED_W-1:1]}  (one-hot MSB..LSB..MSB wrap)
//  01 rot-left : led <= {led[LED_W-2:0], led[LED_W-1]}
//  10 bounce   : dir=RIGHT: if led[0] then dir<=LEFT, led<=led<<1 else led<=led>>1;
//                dir=LEFT : if led[LED_W-1] then dir<=RIGHT, led<=led>>1 else led<=led<<1.
//                Logical shifts, no wrap. Endpoints are shown for one step, with no double-dwell.
//  11 hold     : led unchanged; dir unchanged; tick still pulses.
//  dir is ignored outside bounce, but retained; re-entering bounce resumes the stored dir.
//  Reset mid-period: cnt and led return to reset values at once; the partial period is discarded.
//  Without load, led is always one-hot.
// CONFIGURATION
//  LED_LOAD_EN defined: ports load_stb/load_val are present. load_stb=1 sets led<=load_val and cnt<=0
//   next cycle, and tick=0 that cycle. Load has priority over a coincident step and works with enable=0.
//   Arbitrary patterns rotate as above; in bounce, an all-zero pattern stays zero.
//  LED_LOAD_EN undefined: the ports do not exist and there is no load logic.
// STRUCTURE
//  Package led_pkg: MODE_ROR=2'b00, MODE_ROL=2'b01, MODE_BOUNCE=2'b10, MODE_HOLD=2'b11;
//   DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
//  Sub-module tick_divider #(DIV): sys_clk, sys_rst_n, enable, clr -> tick.
//   Counter width $clog2(DIV), min 1. clr is tied low when LED_LOAD_EN is undefined.
//  Top: divider instance, plus one always block for led/dir.
// TESTING  (LED_W=4, DIV=3 unless noted)
//  1 Reset, enable=1, mode=00 -> led 1000; tick every 3rd cycle; led 0100,0010,0001,1000.
//  2 mode=01 from reset -> 1000 -> 0001 -> 0010 -> 0100 -> 1000.
//  3 mode=10 -> 1000,0100,0010,0001,0010,0100,1000,0100 (no repeated endpoint).
//  4 enable=0 for 5 cycles mid-period -> led and tick frozen; resumes with the remaining count.
//    mode=11 -> tick continues, led constant.
//  5 sys_rst_n low one cycle mid-period, led=0010 -> led=1000 immediately; the next step is 3 cycles
//    after release.
//  6 LED_LOAD_EN: load_val=0101 with load_stb coincident with a tick, mode=00 -> led=0101, no step;
//    next step 1010 after 3 cycles. Also DIV=1: step every cycle.

Source files
------------

// File: rtl/led_pkg.sv
// ============================================================================
//  led_pkg : shared mode encodings and bounce-direction type for led_pattern_gen
//  Revision: 1.0
// ============================================================================
`default_nettype none

package led_pkg;

  localparam logic [1:0] MODE_ROR    = 2'b00;
  localparam logic [1:0] MODE_ROL    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

endpackage

`default_nettype wire

// File: rtl/tick_divider.sv
// ============================================================================
//  tick_divider : clock-enable divider producing one registered tick per DIV
//                 enabled cycles; 'step' is the same event one cycle early.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tick_divider #(
  parameter int DIV = 10_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic enable,
  input  logic clr,
  output logic tick,
  output logic step
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // step lets the owner of the pattern update on the same edge that raises tick
  always_comb begin
    step   = enable && !clr && (cnt_q == CNT_LAST);
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d  = step ? '0 : cnt_q + CNT_W'(1);
      tick_d = step;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/led_pattern_gen.sv
// ============================================================================
//  led_pattern_gen : parametrised LED rotate/bounce/hold pattern generator.
//  Optional macro LED_LOAD_EN adds load_stb/load_val pattern loading.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module led_pattern_gen
  import led_pkg::*;
#(
  parameter int LED_W = 16,
  parameter int DIV   = 10_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led,
  output logic             tick
`ifdef LED_LOAD_EN
  ,
  input  logic             load_stb,
  input  logic [LED_W-1:0] load_val
`endif
);

  localparam logic [LED_W-1:0] LED_RESET = {1'b1, {(LED_W-1){1'b0}}};

  logic [LED_W-1:0] led_q, led_d;
  dir_e             dir_q, dir_d;
  logic             step;
  logic             clr;

`ifdef LED_LOAD_EN
  assign clr = load_stb;
`else
  assign clr = 1'b0;
`endif

  tick_divider #(
    .DIV (DIV)
  ) u_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (enable),
    .clr       (clr),
    .tick      (tick),
    .step      (step)
  );

  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
    if (step) begin
      case (mode)
        MODE_ROR: led_d = {led_q[0], led_q[LED_W-1:1]};
        MODE_ROL: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_BOUNCE: begin
          // turning at an endpoint moves away immediately so ends never dwell twice
          if (dir_q == DIR_RIGHT) begin
            if (led_q[0]) begin
              dir_d = DIR_LEFT;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end else begin
            if (led_q[LED_W-1]) begin
              dir_d = DIR_RIGHT;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end
        end
        MODE_HOLD: led_d = led_q;
        default:   led_d = led_q;
      endcase
    end
`ifdef LED_LOAD_EN
    if (load_stb) begin
      led_d = load_val;
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_q <= LED_RESET;
      dir_q <= DIR_RIGHT;
    end else begin
      led_q <= led_d;
      dir_q <= dir_d;
    end
  end

  assign led = led_q;

endmodule

`default_nettype wire
